// File: rtl/uart_pkg.sv
// Shared UART types: parity selection, transmitter FSM states and format limits.
// The receiver will reuse this package.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam int MIN_DATA_BITS = 5;

endpackage

// File: rtl/uart_bit_timer.sv
// Counts oversampling ticks within one bit period and strobes bit_end on the
// last tick; the period is OVERSAMPLE ticks, or twice that for a double stop bit.
module uart_bit_timer #(
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic tick,
  input  logic double_len,
  output logic bit_end
);

  localparam int CW = $clog2(2 * OVERSAMPLE);
  localparam logic [CW-1:0] LAST_SINGLE = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] LAST_DOUBLE = CW'(2 * OVERSAMPLE - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] last;

  assign last    = double_len ? LAST_DOUBLE : LAST_SINGLE;
  assign bit_end = en && tick && (cnt == last);

  // Held at zero while disabled so the first counted tick always starts a bit.
  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      cnt <= '0;
    end else if (tick) begin
      if (cnt == last) cnt <= '0;
      else             cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start, 5..DATA_BITS data bits LSB first,
// optional parity and 1 or 2 stop bits, format latched per character.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           tick,
  input  logic                           tx_valid,
  output logic                           tx_ready,
  input  logic [DATA_BITS-1:0]           tx_data,
  input  logic [$clog2(DATA_BITS+1)-1:0] cfg_data_bits,
  input  logic [1:0]                     cfg_parity,
  input  logic                           cfg_stop2,
  output logic                           tx,
  output logic                           tx_done,
  output logic                           busy
);

  localparam int NW = $clog2(DATA_BITS + 1);

  // Handshake: a character transfers on a clk edge where tx_valid && tx_ready;
  // tx_ready is high only in IDLE and nothing is buffered.
  tx_state_e            state, state_n;
  logic [DATA_BITS-1:0] shift_q, shift_n;
  logic [NW-1:0]        bit_cnt, bit_cnt_n;
  logic [NW-1:0]        nbits_q, nbits_in;
  logic                 par_en_q, par_bit_q, stop2_q;
  logic                 par_acc, par_in;
  logic                 tx_n;
  logic                 accept;
  logic                 bit_end;

  assign tx_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign accept   = tx_valid && tx_ready;

  always_comb begin
    if (int'(cfg_data_bits) < MIN_DATA_BITS)  nbits_in = NW'(MIN_DATA_BITS);
    else if (int'(cfg_data_bits) > DATA_BITS) nbits_in = NW'(DATA_BITS);
    else                                      nbits_in = cfg_data_bits;
  end

  // Parity covers only the bits actually sent; higher latched bits are ignored.
  always_comb begin
    par_acc = 1'b0;
    for (int i = 0; i < DATA_BITS; i++) begin
      if (i < int'(nbits_in)) par_acc = par_acc ^ tx_data[i];
    end
    par_in = (cfg_parity == PAR_ODD) ? ~par_acc : par_acc;
  end

  uart_bit_timer #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (busy),
    .tick      (tick),
    .double_len((state == STOP) && stop2_q),
    .bit_end   (bit_end)
  );

  // tx_n is the line value for the next state, so tx is a clean register.
  always_comb begin
    state_n   = state;
    shift_n   = shift_q;
    bit_cnt_n = bit_cnt;
    tx_n      = 1'b1;
    tx_done   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_n   = START;
          shift_n   = tx_data;
          bit_cnt_n = '0;
          tx_n      = 1'b0;
        end
      end
      START: begin
        tx_n = 1'b0;
        if (bit_end) begin
          state_n = DATA;
          tx_n    = shift_q[0];
        end
      end
      DATA: begin
        tx_n = shift_q[0];
        if (bit_end) begin
          shift_n = shift_q >> 1;
          if (bit_cnt == nbits_q - NW'(1)) begin
            bit_cnt_n = '0;
            state_n   = par_en_q ? PARITY : STOP;
            tx_n      = par_en_q ? par_bit_q : 1'b1;
          end else begin
            bit_cnt_n = bit_cnt + NW'(1);
            tx_n      = shift_n[0];
          end
        end
      end
      PARITY: begin
        tx_n = par_bit_q;
        if (bit_end) begin
          state_n = STOP;
          tx_n    = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_n = IDLE;
          tx_done = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift_q   <= '0;
      bit_cnt   <= '0;
      nbits_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      tx        <= 1'b1;
    end else begin
      state   <= state_n;
      shift_q <= shift_n;
      bit_cnt <= bit_cnt_n;
      tx      <= tx_n;
      if (accept) begin
        nbits_q   <= nbits_in;
        par_en_q  <= (cfg_parity == PAR_EVEN) || (cfg_parity == PAR_ODD);
        par_bit_q <= par_in;
        stop2_q   <= cfg_stop2;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Randomized bench for uart_tx_cfg: each frame is modelled as a list of line
// bits, and tx/tx_done are checked against the tick count every clock.
module tb_uart_tx_cfg;

  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;
  localparam int NW         = $clog2(DATA_BITS + 1);

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 tick = 1'b0;
  logic                 tx_valid = 1'b0;
  logic                 tx_ready;
  logic [DATA_BITS-1:0] tx_data = '0;
  logic [NW-1:0]        cfg_data_bits = '0;
  logic [1:0]           cfg_parity = '0;
  logic                 cfg_stop2 = 1'b0;
  logic                 tx;
  logic                 tx_done;
  logic                 busy;

  int errors = 0;
  int checks = 0;
  int since_tick = 0;
  logic [0:0] exp_q[$];

  uart_tx_cfg #(
    .DATA_BITS (DATA_BITS),
    .OVERSAMPLE(OVERSAMPLE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick         (tick),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_data      (tx_data),
    .cfg_data_bits(cfg_data_bits),
    .cfg_parity   (cfg_parity),
    .cfg_stop2    (cfg_stop2),
    .tx           (tx),
    .tx_done      (tx_done),
    .busy         (busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not end, got timeout, required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Ticks arrive at random, but never more than two idle clocks apart.
  task automatic drive_tick();
    if (since_tick >= 2) tick = 1'b1;
    else                 tick = ($urandom_range(0, 2) == 0);
    since_tick = tick ? 0 : since_tick + 1;
  endtask

  // Reference frame: start, n data bits LSB first, optional parity, stop bits.
  task automatic build_frame(input logic [DATA_BITS-1:0] d, input int nb, input int par,
                             input bit st2);
    int n;
    int ones;
    exp_q.delete();
    n = (nb < 5) ? 5 : (nb > DATA_BITS) ? DATA_BITS : nb;
    ones = 0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(d[i]);
      if (d[i]) ones++;
    end
    if (par == 1) exp_q.push_back(1'((ones % 2)));
    if (par == 2) exp_q.push_back(1'(1 - (ones % 2)));
    exp_q.push_back(1'b1);
    if (st2) exp_q.push_back(1'b1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_tx"}, 32'(tx), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_ready"}, 32'(tx_ready), 32'd1);
    check({tag, "_done"}, 32'(tx_done), 32'd0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tx_valid = 1'b0;
      drive_tick();
      #1;
      check_idle("idle");
    end
  endtask

  // Offers one character in the current cycle, then follows the frame until
  // its final tick. hold keeps tx_valid high; abort_at pulses reset at that tick count.
  task automatic run_frame(input logic [DATA_BITS-1:0] d, input int nb, input int par,
                           input bit st2, input bit hold, input int abort_at);
    int total;
    int c;
    int cyc;
    build_frame(d, nb, par, st2);
    total = exp_q.size() * OVERSAMPLE;
    @(negedge clk);
    tx_valid      = 1'b1;
    tx_data       = d;
    cfg_data_bits = NW'(nb);
    cfg_parity    = 2'(par);
    cfg_stop2     = st2;
    drive_tick();
    #1;
    check_idle("accept");
    c = 0;
    cyc = 0;
    while (c < total) begin
      @(negedge clk);
      tx_valid      = hold ? 1'b1 : 1'($urandom_range(0, 1));
      tx_data       = DATA_BITS'($urandom);
      cfg_data_bits = NW'($urandom_range(0, (1 << NW) - 1));
      cfg_parity    = 2'($urandom_range(0, 3));
      cfg_stop2     = 1'($urandom_range(0, 1));
      drive_tick();
      if (c == abort_at) rst_n = 1'b0;
      #1;
      check("tx", 32'(tx), 32'(exp_q[c / OVERSAMPLE]));
      check("busy", 32'(busy), 32'd1);
      check("ready", 32'(tx_ready), 32'd0);
      check("done", 32'(tx_done), 32'(tick && (c == total - 1)));
      if (!rst_n) begin
        @(negedge clk);
        rst_n    = 1'b1;
        tx_valid = 1'b0;
        drive_tick();
        #1;
        check_idle("abort");
        return;
      end
      if (tick) c++;
      cyc++;
      if (cyc > 3 * total + 10) begin
        check("timeout", 32'(cyc), 32'(3 * total + 10));
        return;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      drive_tick();
    end
    #1;
    check_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;
    drive_tick();
    #1;
    check_idle("post_reset");

    // 8N1, then 8E2 / 8O1 of 0xA5
    run_frame(8'hA5, 8, 0, 1'b0, 1'b0, -1);
    idle_cycles(3);
    run_frame(8'hA5, 8, 1, 1'b1, 1'b0, -1);
    idle_cycles(2);
    run_frame(8'hA5, 8, 2, 1'b0, 1'b0, -1);
    idle_cycles(2);
    // 5 data bits, odd parity, upper bits set but never sent
    run_frame(8'hFF, 5, 2, 1'b0, 1'b0, -1);
    idle_cycles(1);
    // clamping of data bit count, and encoding 3 as no parity
    run_frame(8'h96, 3, 1, 1'b0, 1'b0, -1);
    idle_cycles(1);
    run_frame(8'h96, 12, 3, 1'b1, 1'b0, -1);
    idle_cycles(2);
    // back-to-back with tx_valid held high and cfg churning mid-frame
    run_frame(8'h31, 7, 1, 1'b0, 1'b1, -1);
    run_frame(8'hC4, 6, 2, 1'b1, 1'b1, -1);
    run_frame(8'h5E, 8, 0, 1'b0, 1'b0, -1);
    idle_cycles(2);
    // reset during data bit 3, then a clean 0x3C
    run_frame(8'hA5, 8, 1, 1'b0, 1'b0, 4 * OVERSAMPLE + OVERSAMPLE / 2);
    idle_cycles(2);
    run_frame(8'h3C, 8, 0, 1'b0, 1'b0, -1);
    idle_cycles(2);

    for (int k = 0; k < 10; k++) begin
      run_frame(DATA_BITS'($urandom), $urandom_range(0, (1 << NW) - 1),
                $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), -1);
      if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 4));
    end
    idle_cycles(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
